// File: rtl/simmem_bank_timer.sv
// Multi-bank DRAM timing model: each bank tracks its open row and counts down the
// access cost, then offers the completed internal ID on a fixed-priority, grant-latched output.
module simmem_bank_timer #(
  parameter int AddrW          = 19,
  parameter int RowBufLenW     = 10,
  parameter int NumBanksW      = 2,
  parameter int RowHitCost     = 10,
  parameter int PrechargeCost  = 50,
  parameter int ActivationCost = 45,
  parameter bit ClosePage      = 1'b0,
  parameter int IidW           = 5,
  parameter int CntW           = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [AddrW-1:0]        req_addr_i,
  input  logic [IidW-1:0]         req_iid_i,
  input  logic                    req_is_write_i,
  output logic                    done_valid_o,
  input  logic                    done_ready_i,
  output logic [IidW-1:0]         done_iid_o,
  output logic                    done_is_write_o,
  output logic [2**NumBanksW-1:0] bank_busy_o
);

  localparam int NumBanks = 2 ** NumBanksW;
  localparam int RowW     = AddrW - RowBufLenW - NumBanksW;

  localparam logic [CntW-1:0] LoadHit  = CntW'(RowHitCost - 1);
  localparam logic [CntW-1:0] LoadAct  = CntW'(ActivationCost + RowHitCost - 1);
  localparam logic [CntW-1:0] LoadMiss = CntW'(PrechargeCost + ActivationCost + RowHitCost - 1);

  if ((PrechargeCost + ActivationCost + RowHitCost - 1) >= (2 ** CntW)) begin : g_cntw_check
    $error("CntW too narrow for the worst-case access cost");
  end
  if (RowHitCost < 1) begin : g_hit_check
    $error("RowHitCost must be at least 1");
  end

  typedef enum logic [1:0] {ST_CLOSED, ST_OPEN, ST_BUSY, ST_DONE} bank_state_e;

  bank_state_e           state_q   [NumBanks];
  logic [CntW-1:0]       timer_q   [NumBanks];
  logic [RowW-1:0]       row_q     [NumBanks];
  logic                  row_vld_q [NumBanks];
  logic [IidW-1:0]       iid_q     [NumBanks];
  logic                  wr_q      [NumBanks];
  logic                  gnt_vld_q, gnt_vld_d;
  logic [NumBanksW-1:0]  gnt_idx_q, gnt_idx_d;

  logic [NumBanksW-1:0]  req_bank;
  logic [RowW-1:0]       req_row;
  logic [CntW-1:0]       req_load;
  logic                  accept;
  logic                  low_vld;
  logic [NumBanksW-1:0]  low_idx;
  logic [NumBanksW-1:0]  sel_idx;
  logic                  handshake;
  logic                  unused_col;

  assign req_bank   = req_addr_i[RowBufLenW +: NumBanksW];
  assign req_row    = req_addr_i[AddrW-1 : RowBufLenW+NumBanksW];
  assign unused_col = ^req_addr_i[RowBufLenW-1:0];

  assign req_ready_o = (state_q[req_bank] == ST_CLOSED) || (state_q[req_bank] == ST_OPEN);
  assign accept      = req_valid_i && req_ready_o;

  // NOTE: always_comb outputs get a default before any branch so no latch is inferred.
  always_comb begin
    req_load = LoadAct;
    if (state_q[req_bank] == ST_OPEN && row_vld_q[req_bank]) begin
      req_load = (row_q[req_bank] == req_row) ? LoadHit : LoadMiss;
    end
  end

  // Fixed priority: scanning downwards leaves the lowest DONE bank as the winner.
  always_comb begin
    low_vld = 1'b0;
    low_idx = '0;
    for (int b = NumBanks - 1; b >= 0; b--) begin
      if (state_q[b] == ST_DONE) begin
        low_vld = 1'b1;
        low_idx = NumBanksW'(b);
      end
    end
  end

  assign sel_idx         = gnt_vld_q ? gnt_idx_q : low_idx;
  assign done_valid_o    = gnt_vld_q || low_vld;
  assign done_iid_o      = done_valid_o ? iid_q[sel_idx] : '0;
  assign done_is_write_o = done_valid_o ? wr_q[sel_idx] : 1'b0;
  assign handshake       = done_valid_o && done_ready_i;

  // The grant holds a stalled winner so a lower bank finishing later cannot swap the payload.
  always_comb begin
    gnt_vld_d = gnt_vld_q;
    gnt_idx_d = gnt_idx_q;
    if (handshake) begin
      gnt_vld_d = 1'b0;
    end else if (done_valid_o) begin
      gnt_vld_d = 1'b1;
      gnt_idx_d = sel_idx;
    end
  end

  always_comb begin
    for (int b = 0; b < NumBanks; b++) begin
      bank_busy_o[b] = (state_q[b] == ST_BUSY) || (state_q[b] == ST_DONE);
    end
  end

  // NOTE: the per-bank registers are a handful of flops, so they are all reset;
  // a reset must drop in-flight requests and forget open rows anyway.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < NumBanks; b++) begin
        state_q[b]   <= ST_CLOSED;
        timer_q[b]   <= '0;
        row_q[b]     <= '0;
        row_vld_q[b] <= 1'b0;
        iid_q[b]     <= '0;
        wr_q[b]      <= 1'b0;
      end
      gnt_vld_q <= 1'b0;
      gnt_idx_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every bank reading pre-edge state.
      for (int b = 0; b < NumBanks; b++) begin
        unique case (state_q[b])
          ST_CLOSED, ST_OPEN: begin
            if (accept && req_bank == NumBanksW'(b)) begin
              state_q[b]   <= ST_BUSY;
              timer_q[b]   <= req_load;
              row_q[b]     <= req_row;
              row_vld_q[b] <= 1'b1;
              iid_q[b]     <= req_iid_i;
              wr_q[b]      <= req_is_write_i;
            end
          end
          ST_BUSY: begin
            if (timer_q[b] == '0) state_q[b] <= ST_DONE;
            else                  timer_q[b] <= timer_q[b] - 1'b1;
          end
          ST_DONE: begin
            if (handshake && sel_idx == NumBanksW'(b)) begin
              state_q[b] <= ClosePage ? ST_CLOSED : ST_OPEN;
              if (ClosePage) row_vld_q[b] <= 1'b0;
            end
          end
          default: state_q[b] <= ST_CLOSED;
        endcase
      end
      gnt_vld_q <= gnt_vld_d;
      gnt_idx_q <= gnt_idx_d;
    end
  end

endmodule

// File: tb/tb_simmem_bank_timer.sv
// Scoreboard bench: an open-page instance (0) and a close-page instance (1) share clock and reset.
module tb_simmem_bank_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [18:0] req_addr   [2];
  logic [4:0]  req_iid    [2];
  logic        req_wr     [2];
  logic        done_valid [2];
  logic        done_ready [2];
  logic [4:0]  done_iid   [2];
  logic        done_wr    [2];
  logic [3:0]  busy       [2];

  simmem_bank_timer #(.ClosePage(1'b0)) dut_open (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_addr_i(req_addr[0]),
    .req_iid_i(req_iid[0]), .req_is_write_i(req_wr[0]),
    .done_valid_o(done_valid[0]), .done_ready_i(done_ready[0]), .done_iid_o(done_iid[0]),
    .done_is_write_o(done_wr[0]), .bank_busy_o(busy[0])
  );

  simmem_bank_timer #(.ClosePage(1'b1)) dut_close (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_addr_i(req_addr[1]),
    .req_iid_i(req_iid[1]), .req_is_write_i(req_wr[1]),
    .done_valid_o(done_valid[1]), .done_ready_i(done_ready[1]), .done_iid_o(done_iid[1]),
    .done_is_write_o(done_wr[1]), .bank_busy_o(busy[1])
  );

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q0 [$];
  logic [5:0] exp_q1 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every completion handshake is compared with the oldest expected entry.
  always @(negedge clk) begin
    logic [5:0] e;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (done_valid[d] && done_ready[d]) begin
          if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done dut%0d: got iid %0d expected none", d, done_iid[d]);
          end else begin
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("done_payload dut%0d", d), {26'd0, done_wr[d], done_iid[d]}, {26'd0, e});
          end
        end
      end
    end
  end

  task automatic issue(input int d, input logic [18:0] a, input logic [4:0] id, input logic w);
    req_valid[d] = 1'b1;
    req_addr[d]  = a;
    req_iid[d]   = id;
    req_wr[d]    = w;
    @(negedge clk);
    check($sformatf("req_ready dut%0d addr %0h", d, a), {31'd0, req_ready[d]}, 32'd1);
    @(posedge clk);
    if (d == 0) exp_q0.push_back({w, id});
    else        exp_q1.push_back({w, id});
    #1 req_valid[d] = 1'b0;
  endtask

  // Counts edges from the accepting edge until done_valid is first visible.
  task automatic meas(input int d, input logic [18:0] a, input logic [4:0] id, input logic w,
                      input int exp_lat);
    int n;
    issue(d, a, id, w);
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done_valid[d]) break;
    end
    check($sformatf("latency dut%0d addr %0h", d, a), n, exp_lat);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_addr[d] = '0; req_iid[d] = '0; req_wr[d] = 1'b0;
      done_ready[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset done_valid", {31'd0, done_valid[0]}, 32'd0);
    check("reset done_iid", {27'd0, done_iid[0]}, 32'd0);
    check("reset done_is_write", {31'd0, done_wr[0]}, 32'd0);
    check("reset bank_busy", {28'd0, busy[0]}, 32'd0);
    check("reset req_ready", {31'd0, req_ready[0]}, 32'd1);
    @(posedge clk);
    #1;

    // Closed row, then same-row hit, then row miss on bank 0.
    meas(0, 19'h00000, 5'd3, 1'b0, 55);
    @(posedge clk); #1;
    meas(0, 19'h00010, 5'd7, 1'b1, 10);
    @(posedge clk); #1;
    meas(0, 19'h01000, 5'd9, 1'b0, 105);
    @(posedge clk); #1;

    // Two banks from CLOSED, output stalled until both are DONE.
    do_reset();
    done_ready[0] = 1'b0;
    issue(0, 19'h00000, 5'd11, 1'b0);
    issue(0, 19'h00400, 5'd12, 1'b1);
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("two_bank done_valid", {31'd0, done_valid[0]}, 32'd1);
    check("two_bank first iid", {27'd0, done_iid[0]}, 32'd11);
    check("two_bank busy", {28'd0, busy[0]}, 32'h3);
    req_addr[0] = 19'h00000;
    #1 check("ready bank0 done", {31'd0, req_ready[0]}, 32'd0);
    req_addr[0] = 19'h00800;
    #1 check("ready bank2 idle", {31'd0, req_ready[0]}, 32'd1);
    @(posedge clk);
    #1 done_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("two_bank second valid", {31'd0, done_valid[0]}, 32'd1);
    check("two_bank second iid", {27'd0, done_iid[0]}, 32'd12);
    check("two_bank second is_write", {31'd0, done_wr[0]}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Grant latch: bank 1 stalled in DONE, bank 0 finishes behind it.
    done_ready[0] = 1'b0;
    issue(0, 19'h00400, 5'd20, 1'b0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("grant bank1 iid", {27'd0, done_iid[0]}, 32'd20);
    @(posedge clk); #1;
    issue(0, 19'h00000, 5'd21, 1'b1);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("grant both busy", {28'd0, busy[0]}, 32'h3);
    check("grant held iid", {27'd0, done_iid[0]}, 32'd20);
    @(posedge clk);
    #1 done_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("grant switched iid", {27'd0, done_iid[0]}, 32'd21);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("queue0 drained", exp_q0.size(), 32'd0);

    // Mid-operation reset drops in-flight requests and forgets open rows.
    issue(0, 19'h01000, 5'd25, 1'b0);
    issue(0, 19'h01400, 5'd26, 1'b0);
    repeat (84) @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    check("post_reset busy", {28'd0, busy[0]}, 32'd0);
    check("post_reset req_ready", {31'd0, req_ready[0]}, 32'd1);
    seen = 0;
    repeat (120) begin
      @(negedge clk);
      if (done_valid[0]) seen++;
    end
    check("post_reset no done", seen, 32'd0);
    @(posedge clk); #1;
    meas(0, 19'h00000, 5'd27, 1'b0, 55);
    @(posedge clk); #1;

    // Close-page instance: every access pays activation, bank idle after each handshake.
    meas(1, 19'h00000, 5'd1, 1'b0, 55);
    @(posedge clk);
    @(negedge clk);
    check("close_page busy after hs", {31'd0, busy[1][0]}, 32'd0);
    @(posedge clk); #1;
    meas(1, 19'h00000, 5'd2, 1'b1, 55);
    @(posedge clk);
    @(negedge clk);
    check("close_page busy after hs2", {28'd0, busy[1]}, 32'd0);
    @(posedge clk); #1;

    check("queue0 empty at end", exp_q0.size(), 32'd0);
    check("queue1 empty at end", exp_q1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
